// File: rtl/spi_byte_master.sv
// Byte-level SPI master, mode 0, MSB first, with a one-byte holding register for back-to-back bytes.
// Define SPI_LOOPBACK_EN to feed the receive shifter from the internal mosi instead of the miso pin.
module spi_byte_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] Byte,
    input  logic       wren,
    output logic       di_req,
    output logic       write_ack,
    output logic [7:0] data_read,
    output logic       data_read_valid,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       ss_n
);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t     state;
    logic [7:0] div_cnt;
    logic [7:0] gap_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] hold_reg;
    logic       hold_valid;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic       last_byte;

    logic div_done;
    logic byte_done;
    logic load_now;
    logic accept;
    logic hold_next;
    logic rx_bit;

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = mosi;
`else
    assign rx_bit = miso;
`endif

    // The shifter drains the holding register before a new byte is accepted into it.
    always_comb begin
        div_done  = (div_cnt == DIV_LAST);
        byte_done = (state == SHIFT) && sclk && div_done && (bit_cnt == 3'd7);
        load_now  = hold_valid && ((state == IDLE) || byte_done);
        accept    = wren && (!hold_valid || load_now) && !write_ack;
        hold_next = accept || (hold_valid && !load_now);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            div_cnt         <= 8'd0;
            gap_cnt         <= 8'd0;
            bit_cnt         <= 3'd0;
            hold_reg        <= 8'd0;
            hold_valid      <= 1'b0;
            tx_shift        <= 8'd0;
            rx_shift        <= 8'd0;
            last_byte       <= 1'b0;
            di_req          <= 1'b1;
            write_ack       <= 1'b0;
            data_read       <= 8'd0;
            data_read_valid <= 1'b0;
            busy            <= 1'b0;
            sclk            <= 1'b0;
            mosi            <= 1'b0;
            ss_n            <= 1'b1;
        end else begin
            write_ack       <= accept;
            data_read_valid <= 1'b0;
            hold_valid      <= hold_next;
            di_req          <= !hold_next;
            if (accept) begin
                hold_reg <= Byte;
            end

            case (state)
                IDLE: begin
                    if (hold_valid) begin
                        state    <= LEAD;
                        busy     <= 1'b1;
                        ss_n     <= 1'b0;
                        tx_shift <= hold_reg;
                        mosi     <= hold_reg[7];
                        div_cnt  <= 8'd0;
                    end
                end
                LEAD: begin
                    if (div_done) begin
                        state     <= SHIFT;
                        sclk      <= 1'b1;
                        rx_shift  <= {rx_shift[6:0], rx_bit};
                        div_cnt   <= 8'd0;
                        bit_cnt   <= 3'd0;
                        last_byte <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (!div_done) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'd0;
                        if (sclk) begin
                            sclk <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                data_read       <= rx_shift;
                                data_read_valid <= 1'b1;
                                bit_cnt         <= 3'd0;
                                if (hold_valid) begin
                                    tx_shift <= hold_reg;
                                    mosi     <= hold_reg[7];
                                end else begin
                                    last_byte <= 1'b1;
                                end
                            end else begin
                                bit_cnt  <= bit_cnt + 3'd1;
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                mosi     <= tx_shift[6];
                            end
                        end else if (last_byte) begin
                            // The last bit keeps its full low half before the chip-select hold starts.
                            state     <= TRAIL;
                            last_byte <= 1'b0;
                        end else begin
                            sclk     <= 1'b1;
                            rx_shift <= {rx_shift[6:0], rx_bit};
                        end
                    end
                end
                TRAIL: begin
                    if (div_done) begin
                        state   <= GAP;
                        ss_n    <= 1'b1;
                        div_cnt <= 8'd0;
                        gap_cnt <= 8'd0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: SPI slave model, frame/timing monitor, table vectors, corner sequences, random stream.
module tb_spi_byte_master;
    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;
    localparam int SINGLE_LEN = 2 * CLK_DIV + 16 * CLK_DIV;
`ifdef SPI_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic [7:0] tx_byte;
    logic       wren;
    logic       di_req;
    logic       write_ack;
    logic [7:0] data_read;
    logic       data_read_valid;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       ss_n;

    spi_byte_master #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clock(clock), .reset(reset), .Byte(tx_byte), .wren(wren),
        .di_req(di_req), .write_ack(write_ack), .data_read(data_read),
        .data_read_valid(data_read_valid), .busy(busy), .sclk(sclk),
        .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard queues
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] miso_q[$];

    // SPI slave model (mode 0): presents MSB first, shifts out after each falling sclk, captures mosi on rising sclk
    logic [7:0] s_tx = 8'd0;
    logic [7:0] s_rx = 8'd0;
    logic [7:0] mosi_last = 8'd0;
    int         s_bit = 7;
    int         s_rises = 0;

    function automatic logic [7:0] next_miso();
        if (miso_q.size() > 0) return miso_q.pop_front();
        return 8'($urandom_range(0, 255));
    endfunction

    always @(negedge ss_n) begin
        s_tx    = next_miso();
        s_bit   = 7;
        s_rises = 0;
        miso    = s_tx[7];
    end

    always @(negedge sclk) begin
        if (ss_n == 1'b0) begin
            if (s_bit == 0) begin
                s_tx  = next_miso();
                s_bit = 7;
            end else begin
                s_bit--;
            end
            miso = s_tx[s_bit];
        end
    end

    always @(posedge sclk) begin
        if (ss_n == 1'b0) begin
            s_rx = {s_rx[6:0], mosi};
            s_rises++;
            if (s_rises % 8 == 0) begin
                mosi_last = s_rx;
                exp_q.push_back(LOOPBACK ? s_rx : s_tx);
                check("mosi_byte_queued", (tx_q.size() > 0), 1);
                if (tx_q.size() > 0) check("mosi_byte", s_rx, tx_q.pop_front());
            end
        end
    end

    // monitor: frame length, gap, sclk period, pulse counts, data_read checks
    int         cyc = 0;
    int         low_len = 0, high_len = 0, last_frame_len = 0, last_high = 0;
    int         frame_bytes = 0, last_rise = 0;
    int         ack_cnt = 0, valid_cnt = 0;
    int         valid_times[$];
    bit         seen_frame = 0, have_rise = 0;
    logic       prev_ss = 1'b1, prev_sclk = 1'b0;
    logic [7:0] last_rd = 8'd0;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            seen_frame = 0;
        end else begin
            if (!ss_n && prev_ss) begin
                if (seen_frame) begin
                    last_high = high_len;
                    check("gap_len_ok", (high_len >= GAP_CYCLES), 1);
                end
                low_len     = 0;
                frame_bytes = 0;
                have_rise   = 0;
            end
            if (ss_n && !prev_ss) begin
                last_frame_len = low_len;
                check("frame_len", low_len, 2 * CLK_DIV + 16 * CLK_DIV * frame_bytes);
                seen_frame = 1;
                high_len   = 0;
            end
            if (!ss_n) low_len++;
            else high_len++;
            if (sclk && !prev_sclk && !ss_n) begin
                if (have_rise) check("sclk_period", cyc - last_rise, 2 * CLK_DIV);
                have_rise = 1;
                last_rise = cyc;
            end
            if (write_ack) ack_cnt++;
            if (data_read_valid) begin
                valid_cnt++;
                frame_bytes++;
                last_rd = data_read;
                valid_times.push_back(cyc);
                check("rd_queue_nonempty", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("data_read", data_read, exp_q.pop_front());
            end
        end
        prev_ss   = ss_n;
        prev_sclk = sclk;
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input int hold_extra);
        tx_byte = b;
        wren    = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (write_ack) break;
        end
        check("ack_wait", write_ack, 1);
        tx_q.push_back(b);
        repeat (hold_extra) @(negedge clock);
        wren = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 5000; k++) begin
            @(negedge clock);
            if (!busy && di_req && ss_n) break;
        end
        check("idle_wait", busy, 0);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] pin;
        logic [7:0] rd;
        int         len;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] tx, input logic [7:0] pin);
        vec_t v;
        v.tx  = tx;
        v.pin = pin;
        v.rd  = LOOPBACK ? tx : pin;
        v.len = SINGLE_LEN;
        return v;
    endfunction

    initial begin
        vec_t vecs[6];
        int   a0, v0, n;

        vecs[0] = mk(8'hA5, 8'h3C);
        vecs[1] = mk(8'h00, 8'h5A);
        vecs[2] = mk(8'hC3, 8'h0F);
        vecs[3] = mk(8'hFF, 8'h00);
        vecs[4] = mk(8'h80, 8'h01);
        vecs[5] = mk(8'h01, 8'hFE);

        reset   = 1'b1;
        wren    = 1'b0;
        tx_byte = 8'd0;
        miso    = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_di_req", di_req, 1);
        check("rst_write_ack", write_ack, 0);
        check("rst_data_read", data_read, 0);
        check("rst_valid", data_read_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ss_n", ss_n, 1);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // single-byte frames
        for (int i = 0; i < 6; i++) begin
            miso_q.delete();
            miso_q.push_back(vecs[i].pin);
            a0 = ack_cnt;
            v0 = valid_cnt;
            send_byte(vecs[i].tx, 0);
            wait_idle();
            check("vec_ack_count", ack_cnt - a0, 1);
            check("vec_valid_count", valid_cnt - v0, 1);
            check("vec_data_read", last_rd, vecs[i].rd);
            check("vec_mosi", mosi_last, vecs[i].tx);
            check("vec_frame_len", last_frame_len, vecs[i].len);
        end

        // two bytes streamed in one frame
        miso_q.delete();
        miso_q.push_back(8'h81);
        miso_q.push_back(8'h7E);
        v0 = valid_cnt;
        send_byte(8'h02, 0);
        send_byte(8'h5A, 0);
        wait_idle();
        n = valid_times.size();
        check("two_valid_count", valid_cnt - v0, 2);
        check("two_frame_len", last_frame_len, 2 * CLK_DIV + 32 * CLK_DIV);
        check("two_valid_spacing", valid_times[n-1] - valid_times[n-2], 16 * CLK_DIV);
        check("two_last_rd", last_rd, LOOPBACK ? 8'h5A : 8'h7E);

        // wren held high after accept while the holding register is still full
        miso_q.delete();
        v0 = valid_cnt;
        send_byte(8'h5A, 0);
        repeat (2) @(negedge clock);
        a0 = ack_cnt;
        send_byte(8'h11, 3);
        wait_idle();
        check("hold_ack_count", ack_cnt - a0, 1);
        check("hold_valid_count", valid_cnt - v0, 2);
        check("hold_mosi", mosi_last, 8'h11);

        // reset in the middle of bit 4
        miso_q.delete();
        v0 = valid_cnt;
        send_byte(8'hFF, 0);
        for (int k = 0; k < 500; k++) begin
            if (s_rises >= 4) break;
            @(negedge clock);
        end
        check("reset_reached_bit4", (s_rises >= 4), 1);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_ss_n", ss_n, 1);
        check("midrst_sclk", sclk, 0);
        check("midrst_busy", busy, 0);
        check("midrst_di_req", di_req, 1);
        check("midrst_valid", data_read_valid, 0);
        reset = 1'b0;
        tx_q.delete();
        repeat (3) @(negedge clock);
        check("midrst_no_valid", valid_cnt - v0, 0);
        miso_q.push_back(8'h69);
        send_byte(8'h96, 0);
        wait_idle();
        check("postrst_valid_count", valid_cnt - v0, 1);
        check("postrst_data_read", last_rd, LOOPBACK ? 8'h96 : 8'h69);
        check("postrst_mosi", mosi_last, 8'h96);

        // next wren arrives during the trailing chip-select hold
        miso_q.delete();
        v0 = valid_cnt;
        send_byte(8'h33, 0);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            if (valid_cnt > v0) break;
        end
        repeat (6) @(negedge clock);
        check("gap_still_framed", ss_n, 0);
        send_byte(8'hCC, 0);
        wait_idle();
        check("gap_valid_count", valid_cnt - v0, 2);
        check("gap_between_frames", (last_high >= GAP_CYCLES), 1);
        check("gap_second_frame_len", last_frame_len, SINGLE_LEN);

        // random stream with random spacing, checked by the slave model and monitor
        miso_q.delete();
        for (int i = 0; i < 24; i++) begin
            send_byte(8'($urandom_range(0, 255)), 0);
            repeat ($urandom_range(0, 120)) @(negedge clock);
        end
        wait_idle();
        repeat (4) @(negedge clock);
        check("exp_q_drained", exp_q.size(), 0);
        check("tx_q_drained", tx_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_byte_master.md
Name: spi_byte_master

Overview:
- Byte-level SPI master (mode 0, MSB first) sitting directly downstream of the sensor-frame/command SPI controller and driving the ESP link pins.
- Accepts one byte per wren/write_ack handshake through a one-byte holding register, so consecutive bytes stream back-to-back inside one chip-select frame.
- Returns each received MISO byte with a one-cycle valid strobe.
- Chip select stays low while bytes keep arriving and is released when the holding register runs dry.

Parameters:
CLK_DIV, 4, system clocks per SCLK half-period; legal range 2..255
GAP_CYCLES, 8, minimum clocks ss_n stays high between frames; legal range 1..255

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
Byte  input  8  byte to transmit; sampled on acceptance
wren  input  1  write request; level, held high until write_ack is seen
di_req  output  1  holding register empty, can accept a byte
write_ack  output  1  one-cycle pulse, byte accepted
data_read  output  8  last received byte
data_read_valid  output  1  one-cycle pulse, data_read updated
busy  output  1  frame in progress (state != IDLE)
sclk  output  1  SPI clock, idle low
mosi  output  1  SPI data out
miso  input  1  SPI data in
ss_n  output  1  chip select, active low

Behaviour:
- Single clock domain. Every register is reset synchronously when reset=1.
- Reset values: di_req=1, write_ack=0, data_read=0, data_read_valid=0, busy=0, sclk=0, mosi=0, ss_n=1, state=IDLE, holding register empty.
- Acceptance rule: accept when wren=1, holding register empty, and write_ack=0.
  - No accept in the write_ack cycle, because the upstream wren is still high there.
  - On accept: Byte is latched into the holding register, hold_valid=1 and write_ack=1 on the next edge.
  - di_req is the registered form of !hold_valid; it falls in the same cycle write_ack rises.
- Load rule: when the shifter is free (LEAD entry or byte completion) and hold_valid=1, the shifter loads the held byte and hold_valid clears. di_req returns to 1 on the following cycle.
- FSM states: IDLE, LEAD, SHIFT, TRAIL, GAP.
  - IDLE -> LEAD: hold_valid=1. In the same edge: ss_n=0, shifter loaded, mosi=bit7.
  - LEAD: lasts CLK_DIV cycles (chip-select setup), then -> SHIFT.
  - SHIFT: per bit, sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
    - miso is sampled on the sclk rising transition.
    - mosi advances to the next bit on the falling transition.
    - 8 bits take 16*CLK_DIV cycles.
  - Byte completion (falling transition of the 8th bit):
    - data_read takes the sampled byte and data_read_valid pulses for 1 cycle.
    - If hold_valid=1, load the next byte and stay in SHIFT with no extra gap; mosi=bit7 of the new byte.
    - Else -> TRAIL.
  - TRAIL: lasts CLK_DIV cycles, then ss_n=1 -> GAP.
  - GAP: lasts GAP_CYCLES cycles, then -> IDLE. Accepts into the holding register are allowed during TRAIL and GAP, but the frame does not restart until IDLE.
- Frame timing for N bytes with timely refill: ss_n low for CLK_DIV + 16*N*CLK_DIV + CLK_DIV cycles.
- Counters: divider is 8 bit and wraps at CLK_DIV-1; bit counter is 3 bit and wraps 7->0 at byte completion.
- Simultaneous events: accept and load in the same cycle. The load uses the old holding contents; the new byte goes to the holding register. Design order: load first, then accept.
- Reset mid-operation: takes effect on the next edge. ss_n goes high and sclk low, the partial byte is discarded with no data_read_valid, and the held byte is discarded.

Optional Feature:
- SPI_LOOPBACK_EN defined: the receive shifter samples the internal mosi instead of the miso pin, and miso is ignored. Each data_read equals the byte just transmitted.
- SPI_LOOPBACK_EN undefined: receive samples miso; no loopback logic is present.

Test Plan:
- CLK_DIV=4. Single byte: wren with Byte=0xA5, miso model returns 0x3C.
  - write_ack is one pulse.
  - mosi bits on the rising edges are 1,0,1,0,0,1,0,1.
  - data_read=0x3C with one data_read_valid.
  - ss_n low for exactly 72 cycles.
- Two bytes 0x02, 0x5A, with the upstream refilling after write_ack:
  - single ss_n frame of 4+128+4=136 cycles.
  - no sclk gap between the bytes.
  - two data_read_valid pulses, 64 cycles apart.
- wren held high for 3 cycles after accept of 0x11: only one write_ack and only one byte shifted.
- Reset asserted at bit 4 of 0xFF:
  - next edge gives ss_n=1, sclk=0, busy=0, di_req=1.
  - no data_read_valid.
  - a new byte afterwards transmits cleanly.
- Back-to-back frames with GAP_CYCLES=8: ss_n stays high for at least 8 cycles between frames even though the next wren arrives during TRAIL.
- SPI_LOOPBACK_EN defined, bytes 0x00, 0xC3, 0xFF: data_read sequence is 0x00, 0xC3, 0xFF regardless of miso.
